// File: rtl/demux_scheduler_4b.sv
// demux_scheduler_4b: valid/ready steering controller for the 4-bit 1:2 demux.
// One-entry lane registers, rr/fixed/data-bit routing, saturating lane counts.
module demux_scheduler_4b (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       clear_counts,
    input  logic [3:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [3:0] data_out0,
    output logic [3:0] data_out1,
    output logic       valid_out0,
    output logic       valid_out1,
    input  logic       pop0,
    input  logic       pop1,
    output logic       select,
    output logic [7:0] count0,
    output logic [7:0] count1
);

    typedef struct packed {
        logic       vld;
        logic [3:0] dat;
    } lane_t;

    lane_t      lane0_q, lane0_d;
    lane_t      lane1_q, lane1_d;
    logic       rr_q, rr_d;
    logic       sel_q, sel_d;
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    logic tgt;
    logic free0;
    logic free1;
    logic xfer;
    logic ld0;
    logic ld1;

    // Target lane, lane-free terms and handshake
    always_comb begin
        tgt = 1'b0;
        unique case (mode)
            2'b00: tgt = rr_q;
            2'b01: tgt = 1'b0;
            2'b10: tgt = 1'b1;
            2'b11: tgt = data_in[3];
        endcase
        // A popping lane can be refilled on the same edge
        free0     = ~lane0_q.vld | pop0;
        free1     = ~lane1_q.vld | pop1;
        ready_out = tgt ? free1 : free0;
        xfer      = valid_in & ready_out;
        ld0       = xfer & ~tgt;
        ld1       = xfer & tgt;
    end

    // Next-state for lanes, round-robin pointer, select and counters
    always_comb begin
        lane0_d     = lane0_q;
        lane1_d     = lane1_q;
        lane0_d.vld = lane0_q.vld & ~pop0;
        lane1_d.vld = lane1_q.vld & ~pop1;
        if (ld0) begin
            lane0_d.vld = 1'b1;
            lane0_d.dat = data_in;
        end
        if (ld1) begin
            lane1_d.vld = 1'b1;
            lane1_d.dat = data_in;
        end
        rr_d  = rr_q ^ (xfer & (mode == 2'b00));
        sel_d = xfer ? tgt : sel_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        // Clear takes priority over a coincident increment
        if (clear_counts) begin
            cnt0_d = 8'd0;
            cnt1_d = 8'd0;
        end else begin
            if (ld0 && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
            if (ld1 && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane0_q <= '0;
            lane1_q <= '0;
            rr_q    <= 1'b0;
            sel_q   <= 1'b0;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign data_out0  = lane0_q.dat;
    assign data_out1  = lane1_q.dat;
    assign valid_out0 = lane0_q.vld;
    assign valid_out1 = lane1_q.vld;
    assign select     = sel_q;
    assign count0     = cnt0_q;
    assign count1     = cnt1_q;

endmodule

// File: tb/tb_demux_scheduler_4b.sv
// tb_demux_scheduler_4b: directed checks of routing, stalls, saturation
// and asynchronous reset for demux_scheduler_4b.
module tb_demux_scheduler_4b;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       clear_counts;
    logic [3:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] data_out0;
    logic [3:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       pop0;
    logic       pop1;
    logic       select;
    logic [7:0] count0;
    logic [7:0] count1;

    int total = 0;
    int bad   = 0;

    demux_scheduler_4b dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .clear_counts (clear_counts),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .valid_out0   (valid_out0),
        .valid_out1   (valid_out1),
        .pop0         (pop0),
        .pop1         (pop1),
        .select       (select),
        .count0       (count0),
        .count1       (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // drive at the falling edge, then settle combinational outputs
    task automatic drv(input logic [1:0] m, input logic v, input logic [3:0] d,
                       input logic p0, input logic p1, input logic clr);
        @(negedge clk);
        mode = m; valid_in = v; data_in = d;
        pop0 = p0; pop1 = p1; clear_counts = clr;
        #1;
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; clear_counts = 1'b0;
        data_in = 4'h0; valid_in = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_v0", {7'd0, valid_out0}, 8'd0);
        chk("rst_v1", {7'd0, valid_out1}, 8'd0);
        chk("rst_d0", {4'd0, data_out0}, 8'd0);
        chk("rst_d1", {4'd0, data_out1}, 8'd0);
        chk("rst_sel", {7'd0, select}, 8'd0);
        chk("rst_c0", count0, 8'd0);
        chk("rst_c1", count1, 8'd0);
        chk("rst_rdy", {7'd0, ready_out}, 8'd1);

        // mode 00, consumers always popping: 1,3 -> lane0, 2,4 -> lane1
        drv(2'b00, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0);
        chk("t1_rdy1", {7'd0, ready_out}, 8'd1);
        edge1();
        chk("t1_v0a", {7'd0, valid_out0}, 8'd1);
        chk("t1_d0a", {4'd0, data_out0}, 8'h1);
        chk("t1_sela", {7'd0, select}, 8'd0);
        drv(2'b00, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0);
        chk("t1_rdy2", {7'd0, ready_out}, 8'd1);
        edge1();
        chk("t1_v1b", {7'd0, valid_out1}, 8'd1);
        chk("t1_d1b", {4'd0, data_out1}, 8'h2);
        chk("t1_v0b", {7'd0, valid_out0}, 8'd0);
        chk("t1_selb", {7'd0, select}, 8'd1);
        drv(2'b00, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t1_d0c", {4'd0, data_out0}, 8'h3);
        chk("t1_selc", {7'd0, select}, 8'd0);
        drv(2'b00, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t1_d1d", {4'd0, data_out1}, 8'h4);
        chk("t1_seld", {7'd0, select}, 8'd1);
        chk("t1_c0", count0, 8'd2);
        chk("t1_c1", count1, 8'd2);
        drv(2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t1_drain0", {7'd0, valid_out0}, 8'd0);
        chk("t1_drain1", {7'd0, valid_out1}, 8'd0);

        // mode 00, consumers idle: 5, 6 fill, 7 stalls until pop0
        drv(2'b00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        edge1();
        chk("t2_d0", {4'd0, data_out0}, 8'h5);
        drv(2'b00, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        edge1();
        chk("t2_d1", {4'd0, data_out1}, 8'h6);
        drv(2'b00, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        chk("t2_stall_rdy", {7'd0, ready_out}, 8'd0);
        edge1();
        chk("t2_stall_d0", {4'd0, data_out0}, 8'h5);
        chk("t2_stall_c0", count0, 8'd3);
        drv(2'b00, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        chk("t2_pop_rdy", {7'd0, ready_out}, 8'd1);
        edge1();
        chk("t2_reload_v0", {7'd0, valid_out0}, 8'd1);
        chk("t2_reload_d0", {4'd0, data_out0}, 8'h7);
        chk("t2_c0", count0, 8'd4);
        chk("t2_c1", count1, 8'd3);
        drv(2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t2_stale_d0", {4'd0, data_out0}, 8'h7);
        chk("t2_empty_v0", {7'd0, valid_out0}, 8'd0);
        // rr is 1 after 5,6,7: one word to lane1 brings it back to 0
        drv(2'b00, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t2_flush_d1", {4'd0, data_out1}, 8'hA);
        drv(2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        edge1();
        chk("t2_flush_v1", {7'd0, valid_out1}, 8'd0);

        // mode 11: route by data_in[3]; rr must hold
        drv(2'b11, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        edge1();
        chk("t3_d1", {4'd0, data_out1}, 8'h9);
        chk("t3_sel9", {7'd0, select}, 8'd1);
        drv(2'b11, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        edge1();
        chk("t3_d0", {4'd0, data_out0}, 8'h3);
        chk("t3_sel3", {7'd0, select}, 8'd0);
        chk("t3_c1", count1, 8'd5);
        drv(2'b00, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        chk("t3_rr_rdy", {7'd0, ready_out}, 8'd0);
        pop0 = 1'b1;
        #1;
        chk("t3_rr_rdy_pop", {7'd0, ready_out}, 8'd1);
        edge1();
        chk("t3_rr_d0", {4'd0, data_out0}, 8'hC);
        chk("t3_rr_d1", {4'd0, data_out1}, 8'h9);
        chk("t3_c0", count0, 8'd6);

        // mode 01 with lane0 full and lane1 empty: no transfer
        drv(2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        edge1();
        chk("t4_v1", {7'd0, valid_out1}, 8'd0);
        drv(2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        edge1();
        chk("t4_clr_c0", count0, 8'd0);
        drv(2'b01, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("t4_rdy", {7'd0, ready_out}, 8'd0);
        edge1();
        chk("t4_v1_hold", {7'd0, valid_out1}, 8'd0);
        chk("t4_c1", count1, 8'd0);
        chk("t4_d0", {4'd0, data_out0}, 8'hC);

        // mode 10, 300 words with pop1 every cycle: count1 saturates
        for (int i = 0; i < 300; i++) begin
            drv(2'b10, 1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
            edge1();
            if (i == 253) chk("t5_c1_254", count1, 8'd254);
            if (i == 254) chk("t5_c1_255", count1, 8'd255);
        end
        chk("t5_c1_sat", count1, 8'd255);
        chk("t5_c0", count0, 8'd0);
        chk("t5_d1", {4'd0, data_out1}, 8'hB);
        drv(2'b10, 1'b1, 4'h6, 1'b0, 1'b1, 1'b1);
        edge1();
        chk("t5_clr_c1", count1, 8'd0);
        chk("t5_clr_d1", {4'd0, data_out1}, 8'h6);
        drv(2'b10, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        edge1();
        chk("t5_after_c1", count1, 8'd1);

        // asynchronous reset between edges
        drv(2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_v0", {7'd0, valid_out0}, 8'd1);
        chk("t6_pre_v1", {7'd0, valid_out1}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_v0", {7'd0, valid_out0}, 8'd0);
        chk("t6_v1", {7'd0, valid_out1}, 8'd0);
        chk("t6_sel", {7'd0, select}, 8'd0);
        chk("t6_c1", count1, 8'd0);
        chk("t6_d0", {4'd0, data_out0}, 8'd0);
        chk("t6_rdy", {7'd0, ready_out}, 8'd1);
        @(negedge clk);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
